// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
// Contents:
//   state_t  - arbiter FSM states (IDLE, BUSY)
//   NUM_REQ  - number of requesters sharing the mux
//   SEL_W    - width of the mux select / requester index
//   rr_pick  - round-robin pick: first set request bit scanning from ptr upward, modulo NUM_REQ
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Scans offsets from high to low so that the lowest offset from ptr wins.
  // The index arithmetic wraps naturally in SEL_W bits, giving the 3->0 wrap.
  // Returns ptr when req is all zero; callers only use it when req != 0.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux41_bus.sv
// DW-wide 4:1 data mux, purely combinational.
// Ports:
//   sel   - lane select (2 bits)
//   lanes - packed input lanes; lane i is lanes[i*DW +: DW]
//   out   - selected lane
module mux41_bus
  import mux_arb_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_REQ*DW-1:0] lanes,
  output logic [DW-1:0]         out
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    out = lanes[0 +: DW];
    case (sel)
      2'd1:    out = lanes[1*DW +: DW];
      2'd2:    out = lanes[2*DW +: DW];
      2'd3:    out = lanes[3*DW +: DW];
      default: out = lanes[0 +: DW];
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data mux between four requesters
// in front of a single valid/ready consumer. A grant is held for up to
// MAX_HOLD accepted beats or until the granted requester drops req; each
// release is followed by one idle bubble cycle and priority rotates to sel+1.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   req       - per-requester request, held high while the requester has data
//   in_data   - packed lanes, lane i is in_data[i*DW +: DW]
//   out_ready - consumer accepts a beat this cycle
//   out_valid - out_data carries a valid beat
//   out_data  - data of the granted lane
//   out_src   - index of the granted lane (mux select)
//   gnt       - one-hot grant, zero when idle
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*DW-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [SEL_W-1:0]      out_src,
  output logic [NUM_REQ-1:0]    gnt
);

  localparam int CNT_W = $clog2(MAX_HOLD) + 1;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             last_beat;
  logic             release_now;

  // out_valid follows req[sel] combinationally so a dropped request withdraws
  // the beat in the same cycle; the select itself is only ever a register.
  assign out_valid   = (state == BUSY) && req[sel];
  assign xfer        = out_valid && out_ready;
  assign last_beat   = (cnt == CNT_W'(MAX_HOLD - 1));
  assign release_now = !req[sel] || (xfer && last_beat);
  assign out_src     = sel;

  mux41_bus #(
    .DW(DW)
  ) u_mux (
    .sel  (sel),
    .lanes(in_data),
    .out  (out_data)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= rr_pick(req, ptr);
            gnt   <= NUM_REQ'(1) << rr_pick(req, ptr);
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr   <= sel + SEL_W'(1);
            cnt   <= '0;
            gnt   <= '0;
            state <= IDLE;
          end else if (xfer) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter. Stimulus pushes expected beats
// into a scoreboard queue; a negedge monitor pops and compares each accepted
// beat. Directed grant-timing checks run alongside in the stimulus thread.
module tb_mux4_rr_arbiter;

  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [4*DW-1:0] in_data;
  logic            out_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic [3:0]      gnt;

  logic [DW-1:0] lane [4];
  logic          bp_pat [6];
  beat_t         exp_q [$];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  assign in_data = {lane[3], lane[2], lane[1], lane[0]};

  mux4_rr_arbiter #(
    .DW      (DW),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .gnt      (gnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int src, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.src  = 2'(src);
      b.data = lane[src];
      exp_q.push_back(b);
    end
  endtask

  // Monitor: a beat is accepted at the next rising edge when valid & ready,
  // both stable at the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra_beat: got src=%0d data=0x%0h, expected no beat (t=%0t)",
                 out_src, out_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_src", 32'(out_src), 32'(e.src));
        check("sb_data", 32'(out_data), 32'(e.data));
        check("sb_gnt", 32'(gnt), 32'(4'b0001 << e.src));
      end
    end
  end

  initial begin
    int p;
    int g;
    lane[0] = 8'h10;
    lane[1] = 8'hA5;
    lane[2] = 8'h3C;
    lane[3] = 8'hC3;
    bp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;

    // Reset values
    #2;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_src", 32'(out_src), 32'h0);
    check("reset_data", 32'(out_data), 32'(lane[0]));
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester: lane 1, four beats, bubble, regrant of lane 1
    req       = 4'b0010;
    out_ready = 1'b1;
    push(1, 4);
    tick();
    check("single_gnt", 32'(gnt), 32'h2);
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_src", 32'(out_src), 32'h1);
    tick(); tick(); tick();
    check("single_hold", 32'(gnt), 32'h2);
    tick();
    check("single_bubble", 32'(gnt), 32'h0);
    tick();
    check("single_regrant", 32'(gnt), 32'h2);
    req = 4'b0000;
    #1;
    check("single_drop_valid", 32'(out_valid), 32'h0);
    tick();
    check("single_release", 32'(gnt), 32'h0);

    // Early drop: ptr=2, lane 2 granted, drops after 2 beats
    req = 4'b0100;
    push(2, 2);
    tick();
    check("drop_gnt", 32'(gnt), 32'h4);
    tick(); tick();
    req = 4'b0000;
    #1;
    check("drop_valid", 32'(out_valid), 32'h0);
    check("drop_gnt_held", 32'(gnt), 32'h4);
    tick();
    check("drop_release", 32'(gnt), 32'h0);

    // Wrap and ignore: ptr=3 must pick lane 3 over lane 0; no preemption;
    // then ptr wraps to 0 and lane 0 wins
    req = 4'b1001;
    push(3, 4);
    tick();
    check("wrap_ptr3_pick", 32'(gnt), 32'h8);
    tick(); tick(); tick();
    check("wrap_no_preempt", 32'(gnt), 32'h8);
    tick();
    check("wrap_bubble", 32'(gnt), 32'h0);
    tick();
    check("wrap_to_lane0", 32'(gnt), 32'h1);
    check("wrap_src0", 32'(out_src), 32'h0);
    req = 4'b0000;
    tick();
    check("wrap_release", 32'(gnt), 32'h0);

    // Backpressure: ptr=1, lane 0 granted, out_ready 1,0,0,1,1,1
    req = 4'b0001;
    push(0, 4);
    tick();
    check("bp_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 6; i++) begin
      out_ready = bp_pat[i];
      tick();
      if (i < 5) check("bp_hold", 32'(gnt), 32'h1);
      else       check("bp_release", 32'(gnt), 32'h0);
    end
    req       = 4'b0000;
    out_ready = 1'b1;

    // Reset mid-grant: ptr=1, lane 2 granted, one beat, then async reset
    req = 4'b0100;
    push(2, 1);
    tick();
    check("rst_pre_gnt", 32'(gnt), 32'h4);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_gnt", 32'(gnt), 32'h0);
    check("rst_async_valid", 32'(out_valid), 32'h0);
    check("rst_async_src", 32'(out_src), 32'h0);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin from ptr=0 with all requesting: 0,1,2,3,0, 4 beats each + bubble
    push(0, 4);
    push(1, 4);
    push(2, 4);
    push(3, 4);
    push(0, 4);
    for (int k = 1; k <= 25; k++) begin
      tick();
      p = (k - 1) % 5;
      g = ((k - 1) / 5) % 4;
      check($sformatf("rr_gnt_k%0d", k), 32'(gnt), (p == 4) ? 32'h0 : (32'h1 << g));
    end
    req = 4'b0000;

    tick(); tick(); tick();
    check("final_idle", 32'(gnt), 32'h0);
    check("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
